riscv_test_monitor: RTL and testbench
=====================================

// Module: riscv_test_monitor
// PURPOSE
//  Synthesisable end-of-test detector for riscv-tests programs running on Core.
//  Watches the retire PC, gp (x3) and data-memory stores.
//  Detects pass, fail or timeout and latches a sticky verdict, the failing test
//  number and the cycle count. Testbenches then only poll done/passed.
//  Instantiated beside Core in every rv32ui-p-* bench.
// PARAMETERS
//  XLEN         32        data/address width
//  PASS_PC      32'h44    retire PC that marks end of test (PC mode)
//  TOHOST_ADDR  32'h1000  store address of the tohost word (TOHOST mode)
//  MODE         2         0 = PC match only, 1 = tohost only, 2 = both
//  TIMEOUT      5000      cycles after reset release before timed_out; 0 = never
//  CNT_W        32        width of the cycle counter (must hold TIMEOUT)
// PORTS
//  clk        in   1      clock; all state changes on posedge
//  rst        in   1      synchronous, active-high reset
//  ret_valid  in   1      an instruction retires this cycle
//  ret_pc     in   XLEN   PC of the retiring instruction
//  gp_val     in   XLEN   current value of register x3
//  st_valid   in   1      data-memory store this cycle
//  st_addr    in   XLEN   store byte address
//  st_data    in   XLEN   store data (full word)
//  done       out  1      verdict latched (sticky)
//  passed     out  1      test passed (sticky)
//  failed     out  1      test failed (sticky)
//  timed_out  out  1      TIMEOUT reached with no verdict (sticky)
//  fail_id    out  XLEN   failing test number = code >> 1; 0 unless failed
//  cycles     out  CNT_W  cycles since reset release; frozen when done
// BEHAVIOUR
//  Reset: state=RUN; done, passed, failed, timed_out, fail_id and cycles all 0.
//   Reset asserted mid-run or after a verdict returns to RUN and clears everything.
//  FSM states: RUN -> PASS | FAIL | TMO. Terminal states hold until rst.
//  PC event (MODE 0/2): ret_valid && ret_pc==PASS_PC; code = gp_val.
//  Tohost event (MODE 1/2): st_valid && st_addr==TOHOST_ADDR && st_data[0]==1;
//   code = st_data. An even-valued store to tohost is ignored.
//  Verdict: code==1 -> PASS; any other code -> FAIL with fail_id = code>>1 (logical).
//  Priority in one cycle: tohost event > PC event > timeout.
//  Only the first event counts; later events in PASS/FAIL/TMO have no effect.
//  Latency: an event sampled at edge N is visible on outputs after edge N
//   (registered, 1 cycle). done = passed|failed|timed_out.
//  cycles increments every cycle in RUN, starting from 0 after the rst cycle.
//   In the verdict cycle it updates to its final value, then freezes.
//   Saturates at all-ones; it never wraps.
//  Timeout: in RUN with no event and cycles==TIMEOUT-1 -> TMO. Not checked when TIMEOUT==0.
//  Inputs are don't-care while rst is high.
// STRUCTURE
//  Shared header riscv_test_defs: MODE_PC/MODE_TOHOST/MODE_BOTH constants and the
//   2-bit state encoding (RUN=0, PASS=1, FAIL=2, TMO=3), reused by the benches.
//  One sub-module: sat_counter (CNT_W, parameterised enable/clear; saturating).
//  Rest is the FSM and the event decode in this file.
// TESTING
//  MODE=0, retire pc=0x44 with gp=1 at cycle 20 -> next cycle done=1, passed=1, fail_id=0, cycles=21
//  MODE=0, pc=0x44 with gp=0x7 -> failed=1, fail_id=3. A later pc=0x44 with gp=1 -> outputs unchanged
//  MODE=2, same cycle: tohost store 0x1 and pc hit with gp=0x5 -> passed=1 (tohost wins)
//  MODE=1: tohost store 0x4 (even) -> ignored, stays RUN; then store 0xB -> failed, fail_id=5
//  TIMEOUT=50, no events -> timed_out=1 after cycle 50, cycles=50; a pc hit at that edge -> verdict wins
//  rst pulsed 1 cycle while PASS latched -> all outputs 0; cycles restarts from 0; fresh pass detected

Source files
------------

// File: rtl/riscv_test_defs.sv
// Shared definitions for the riscv-tests end-of-test monitor and its benches.
//   MODE_*  : selects which end-of-test events the monitor listens to
//   state_t : 2-bit verdict state encoding (RUN=0, PASS=1, FAIL=2, TMO=3)
package riscv_test_defs;

    localparam int MODE_PC     = 0;  // retire-PC match only
    localparam int MODE_TOHOST = 1;  // tohost store only
    localparam int MODE_BOTH   = 2;  // either event

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   srst  : synchronous active-high clear to zero
//   en    : count enable; holds the value when low
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test detector for riscv-tests programs. Watches the retire PC / gp
// and stores to the tohost word, then latches a sticky pass/fail/timeout
// verdict together with the failing test number and the elapsed cycle count.
//   clk, rst              : clock, synchronous active-high reset
//   ret_valid/ret_pc      : retiring instruction and its PC
//   gp_val                : current x3 (holds the test code in PC mode)
//   st_valid/addr/data    : data-memory store
//   done/passed/failed/timed_out : sticky verdict flags
//   fail_id               : failing test number (code >> 1), 0 unless failed
//   cycles                : cycles since reset release, frozen once done
module riscv_test_monitor
    import riscv_test_defs::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] PASS_PC     = 32'h44,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
    parameter int              MODE        = 2,
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ret_valid,
    input  logic [XLEN-1:0]  ret_pc,
    input  logic [XLEN-1:0]  gp_val,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             passed,
    output logic             failed,
    output logic             timed_out,
    output logic [XLEN-1:0]  fail_id,
    output logic [CNT_W-1:0] cycles
);

    localparam bit USE_PC     = (MODE == MODE_PC)     || (MODE == MODE_BOTH);
    localparam bit USE_TOHOST = (MODE == MODE_TOHOST) || (MODE == MODE_BOTH);
    localparam bit TMO_EN     = (TIMEOUT != 0);
    // Last RUN cycle before timeout; unused when the timeout is disabled.
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] fail_id_reg, fail_id_next;
    logic            tohost_hit, pc_hit, tmo_hit;
    logic [XLEN-1:0] code;
    logic [CNT_W-1:0] cycle_cnt;

    // Even tohost values are not end-of-test markers, so bit 0 gates the event.
    assign tohost_hit = USE_TOHOST && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
    assign pc_hit     = USE_PC && ret_valid && (ret_pc == PASS_PC);
    assign tmo_hit    = TMO_EN && (cycle_cnt == TMO_LAST);
    // tohost outranks the PC match when both fire together.
    assign code       = tohost_hit ? st_data : gp_val;

    always_comb begin
        state_next   = state_reg;
        fail_id_next = fail_id_reg;
        if (state_reg == ST_RUN) begin
            if (tohost_hit || pc_hit) begin
                if (code == XLEN'(1)) begin
                    state_next = ST_PASS;
                end else begin
                    state_next   = ST_FAIL;
                    fail_id_next = code >> 1;
                end
            end else if (tmo_hit) begin
                state_next = ST_TMO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            fail_id_reg <= '0;
        end else begin
            state_reg   <= state_next;
            fail_id_reg <= fail_id_next;
        end
    end

    // Counting while in RUN includes the verdict cycle, so the count freezes
    // at its final value from the edge that latches the verdict.
    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .srst  (rst),
        .en    (state_reg == ST_RUN),
        .count (cycle_cnt)
    );

    assign passed    = (state_reg == ST_PASS);
    assign failed    = (state_reg == ST_FAIL);
    assign timed_out = (state_reg == ST_TMO);
    assign done      = passed | failed | timed_out;
    assign fail_id   = fail_id_reg;
    assign cycles    = cycle_cnt;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: four instances with different MODE / TIMEOUT /
// CNT_W share one stimulus stream; expected outputs are queued per instance
// before each edge and compared one edge later.
//   d0: MODE 0, TIMEOUT 5000, CNT_W 32
//   d1: MODE 1, TIMEOUT 0 (never), CNT_W 32
//   d2: MODE 2, TIMEOUT 50, CNT_W 32
//   d3: MODE 0, TIMEOUT 0, CNT_W 4 (saturates at 15)
module tb_riscv_test_monitor;

    localparam int NDUT = 4;
    localparam int K_RUN = 0, K_PASS = 1, K_FAIL = 2, K_TMO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [31:0] gp_val = '0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;

    logic        dn [NDUT];
    logic        ps [NDUT];
    logic        fl [NDUT];
    logic        to [NDUT];
    logic [31:0] fid[NDUT];
    logic [31:0] cyc[NDUT];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int P_MODE = (gi == 1) ? 1 : (gi == 2) ? 2 : 0;
            localparam int P_TMO  = (gi == 0) ? 5000 : (gi == 2) ? 50 : 0;
            localparam int P_CW   = (gi == 3) ? 4 : 32;
            logic [P_CW-1:0] cyc_w;
            riscv_test_monitor #(
                .XLEN(32), .PASS_PC(32'h44), .TOHOST_ADDR(32'h1000),
                .MODE(P_MODE), .TIMEOUT(P_TMO), .CNT_W(P_CW)
            ) u_dut (
                .clk(clk), .rst(rst),
                .ret_valid(ret_valid), .ret_pc(ret_pc), .gp_val(gp_val),
                .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
                .done(dn[gi]), .passed(ps[gi]), .failed(fl[gi]), .timed_out(to[gi]),
                .fail_id(fid[gi]), .cycles(cyc_w)
            );
            assign cyc[gi] = 32'(cyc_w);
        end
    endgenerate

    typedef struct {
        string       tag;
        int          dut;
        int          kind;
        logic [31:0] fid;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input int kind,
                              input logic [31:0] f, input logic [31:0] c);
        exp_t e;
        e.tag = tag; e.dut = d; e.kind = kind; e.fid = f; e.cyc = c;
        sb.push_back(e);
    endtask

    // Advance one edge, release the one-shot strobes, then drain the scoreboard.
    task automatic tick(input string tag);
        exp_t e;
        int   i;
        @(posedge clk);
        #1;
        ret_valid = 1'b0;
        st_valid  = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            i = e.dut;
            check($sformatf("%s.d%0d.done",      e.tag, i), 32'(dn[i]), 32'(e.kind != K_RUN));
            check($sformatf("%s.d%0d.passed",    e.tag, i), 32'(ps[i]), 32'(e.kind == K_PASS));
            check($sformatf("%s.d%0d.failed",    e.tag, i), 32'(fl[i]), 32'(e.kind == K_FAIL));
            check($sformatf("%s.d%0d.timed_out", e.tag, i), 32'(to[i]), 32'(e.kind == K_TMO));
            check($sformatf("%s.d%0d.fail_id",   e.tag, i), fid[i], e.fid);
            check($sformatf("%s.d%0d.cycles",    e.tag, i), cyc[i], e.cyc);
        end
        $display("txn %s: d0 st=%0d/%0d/%0d fid=%0d cyc=%0d | d1 %0d/%0d cyc=%0d | d2 %0d/%0d/%0d cyc=%0d | d3 cyc=%0d",
                 tag, ps[0], fl[0], to[0], fid[0], cyc[0], ps[1], fl[1], cyc[1],
                 ps[2], fl[2], to[2], cyc[2], cyc[3]);
    endtask

    task automatic idle(input int n);
        ret_valid = 1'b0;
        st_valid  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        // Inputs are don't-care in reset; drive a would-be event to prove it.
        ret_valid = 1'b1; ret_pc = 32'h44; gp_val = 32'h1;
        for (int d = 0; d < NDUT; d++) expect_out(tag, d, K_RUN, 0, 0);
        tick(tag);
        rst = 1'b0;
    endtask

    task automatic drive_pc(input logic [31:0] pc, input logic [31:0] gp);
        ret_valid = 1'b1; ret_pc = pc; gp_val = gp;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [31:0] dat);
        st_valid = 1'b1; st_addr = a; st_data = dat;
    endtask

    initial begin
        // S1: PC pass at cycle 20
        do_reset("rst1");
        idle(20);
        drive_pc(32'h44, 32'h1);
        expect_out("pc_pass", 0, K_PASS, 0, 21);
        expect_out("pc_pass", 1, K_RUN,  0, 21);
        expect_out("pc_pass", 2, K_PASS, 0, 21);
        expect_out("pc_pass", 3, K_PASS, 0, 15);
        tick("pc_pass");

        // S2: PC fail with gp=7, then a later pass hit is ignored
        do_reset("rst2");
        idle(5);
        drive_pc(32'h44, 32'h7);
        expect_out("pc_fail", 0, K_FAIL, 3, 6);
        expect_out("pc_fail", 1, K_RUN,  0, 6);
        expect_out("pc_fail", 2, K_FAIL, 3, 6);
        expect_out("pc_fail", 3, K_FAIL, 3, 6);
        tick("pc_fail");
        idle(2);
        drive_pc(32'h44, 32'h1);
        expect_out("sticky", 0, K_FAIL, 3, 6);
        expect_out("sticky", 1, K_RUN,  0, 9);
        expect_out("sticky", 2, K_FAIL, 3, 6);
        expect_out("sticky", 3, K_FAIL, 3, 6);
        tick("sticky");

        // S3: tohost pass and PC hit (gp=5) in the same cycle
        do_reset("rst3");
        idle(3);
        drive_pc(32'h44, 32'h5);
        drive_st(32'h1000, 32'h1);
        expect_out("both", 0, K_FAIL, 2, 4);
        expect_out("both", 1, K_PASS, 0, 4);
        expect_out("both", 2, K_PASS, 0, 4);
        expect_out("both", 3, K_FAIL, 2, 4);
        tick("both");

        // S4: even tohost store and wrong address ignored, odd store fails
        do_reset("rst4");
        idle(2);
        drive_st(32'h1000, 32'h4);
        drive_pc(32'h40, 32'h1);
        for (int d = 0; d < 3; d++) expect_out("even", d, K_RUN, 0, 3);
        expect_out("even", 3, K_RUN, 0, 3);
        tick("even");
        drive_st(32'h1004, 32'h1);
        for (int d = 0; d < NDUT; d++) expect_out("badaddr", d, K_RUN, 0, 4);
        tick("badaddr");
        drive_st(32'h1000, 32'hB);
        expect_out("odd", 0, K_RUN,  0, 5);
        expect_out("odd", 1, K_FAIL, 5, 5);
        expect_out("odd", 2, K_FAIL, 5, 5);
        expect_out("odd", 3, K_RUN,  0, 5);
        tick("odd");

        // S5: timeout at 50, then frozen
        do_reset("rst5");
        idle(48);
        expect_out("pre_tmo", 2, K_RUN, 0, 49);
        expect_out("pre_tmo", 3, K_RUN, 0, 15);
        tick("pre_tmo");
        expect_out("tmo", 0, K_RUN, 0, 50);
        expect_out("tmo", 1, K_RUN, 0, 50);
        expect_out("tmo", 2, K_TMO, 0, 50);
        expect_out("tmo", 3, K_RUN, 0, 15);
        tick("tmo");
        drive_pc(32'h44, 32'h1);
        expect_out("post_tmo", 0, K_PASS, 0, 51);
        expect_out("post_tmo", 2, K_TMO,  0, 50);
        tick("post_tmo");

        // S6: verdict beats timeout on the same edge
        do_reset("rst6");
        idle(49);
        drive_pc(32'h44, 32'h1);
        expect_out("race", 0, K_PASS, 0, 50);
        expect_out("race", 1, K_RUN,  0, 50);
        expect_out("race", 2, K_PASS, 0, 50);
        expect_out("race", 3, K_PASS, 0, 15);
        tick("race");

        // S7: reset pulse while PASS latched, then fresh pass
        do_reset("rst7");
        idle(2);
        drive_pc(32'h44, 32'h1);
        expect_out("repass", 0, K_PASS, 0, 3);
        expect_out("repass", 1, K_RUN,  0, 3);
        expect_out("repass", 2, K_PASS, 0, 3);
        expect_out("repass", 3, K_PASS, 0, 3);
        tick("repass");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
